rvh_l1d_wbq: RTL

//  Parametrised L1D eviction write-back queue, successor to the single-outstanding EWRQ.

---
 rtl/rvh_l1d_pkg.sv | 52 +++++
 rtl/rvh_l1d_wbq_wbeat.sv | 42 ++++
 rtl/rvh_l1d_wbq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rvh_l1d_pkg.sv
// Shared L1D types and sizes: write-back queue entry states and the AXI channel
// payloads exchanged between the data cache and the L2.
package rvh_l1d_pkg;

  localparam int N_EWRQ                  = 4;
  localparam int L1D_BANK_LINE_ADDR_SIZE = 27;
  localparam int L1D_BANK_LINE_DATA_SIZE = 256;
  localparam int MEM_DATA_WIDTH          = 64;
  localparam int BURST_SIZE              = L1D_BANK_LINE_DATA_SIZE / MEM_DATA_WIDTH;
  localparam int L1D_OFFSET_W            = $clog2(L1D_BANK_LINE_DATA_SIZE / 8);
  localparam int PADDR_W                 = L1D_BANK_LINE_ADDR_SIZE + L1D_OFFSET_W;
  localparam int WBQ_IDX_W               = $clog2(N_EWRQ);
  localparam int MEM_BID_W               = 4;
  localparam int MEM_TID_W               = 4;

  localparam logic [2:0] AXI_SIZE       = 3'($clog2(MEM_DATA_WIDTH / 8));
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    FREE,
    AW_PEND,
    W_PEND,
    B_WAIT,
    DONE
  } wbq_state_e;

  typedef struct packed {
    logic [MEM_BID_W-1:0] bid;
    logic [MEM_TID_W-1:0] tid;
  } mem_tid_t;

  typedef struct packed {
    mem_tid_t             awid;
    logic [PADDR_W-1:0]   awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
  } cache_mem_if_aw_t;

  typedef struct packed {
    mem_tid_t                  wid;
    logic [MEM_DATA_WIDTH-1:0] wdata;
    logic                      wlast;
  } cache_mem_if_w_t;

  typedef struct packed {
    mem_tid_t   bid;
    logic [1:0] bresp;
  } cache_mem_if_b_t;

endpackage

// File: rtl/rvh_l1d_wbq_wbeat.sv
// W-channel beat sequencer for one cache line: beat counter, wlast flag and
// beat-select mux. The counter only moves on an accepted beat.
module rvh_l1d_wbq_wbeat #(
  parameter int LINE_W    = 256,
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] i_line,
  input  logic              i_valid,
  input  logic              i_ready,
  output logic [BEAT_W-1:0] o_data,
  output logic              o_last,
  output logic              o_last_hs
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [CNT_W-1:0] r_beat;
  logic             w_hs;

  assign w_hs      = i_valid & i_ready;
  assign o_last    = (r_beat == CNT_W'(BURST_LEN - 1));
  assign o_last_hs = w_hs & o_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat <= '0;
    end else if (w_hs) begin
      r_beat <= o_last ? '0 : r_beat + CNT_W'(1);
    end
  end

  always_comb begin
    o_data = '0;
    for (int i = 0; i < BURST_LEN; i++) begin
      if (r_beat == CNT_W'(i)) o_data = i_line[i*BEAT_W +: BEAT_W];
    end
  end

endmodule

// File: rtl/rvh_l1d_wbq.sv
// L1D eviction write-back queue: several outstanding AXI line writes, each entry
// retired in order after its own (possibly out-of-order) B. Optional victim data
// forwarding on the lookup port is enabled by defining RVH_L1D_WBQ_FWD_EN.
module rvh_l1d_wbq
  import rvh_l1d_pkg::*;
#(
  parameter int BANK_ID   = 0,
  parameter int N_ENTRY   = N_EWRQ,
  parameter int ADDR_W    = L1D_BANK_LINE_ADDR_SIZE,
  parameter int LINE_W    = L1D_BANK_LINE_DATA_SIZE,
  parameter int BEAT_W    = MEM_DATA_WIDTH,
  parameter int BURST_LEN = BURST_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_valid_i,
  input  logic [ADDR_W-1:0]         new_addr_i,
  input  logic [LINE_W-1:0]         new_dat_i,
  output logic                      new_ready_o,
  input  logic [ADDR_W-1:0]         lkp_addr_i,
  output logic                      lkp_hit_o,
  output logic [LINE_W-1:0]         lkp_dat_o,
  output logic [N_ENTRY*ADDR_W-1:0] entry_addr_o,
  output logic [N_ENTRY-1:0]        entry_vld_o,
  output logic                      idle_o,
  output logic                      err_o,
  output logic                      l2_req_if_awvalid,
  input  logic                      l2_req_if_awready,
  output cache_mem_if_aw_t          l2_req_if_aw,
  output logic                      l2_req_if_wvalid,
  input  logic                      l2_req_if_wready,
  output cache_mem_if_w_t           l2_req_if_w,
  input  logic                      l2_resp_if_bvalid,
  output logic                      l2_resp_if_bready,
  input  cache_mem_if_b_t           l2_resp_if_b
);

  localparam int IDX_W = $clog2(N_ENTRY);

  wbq_state_e        r_state [N_ENTRY];
  logic [ADDR_W-1:0] r_addr  [N_ENTRY];
  logic [LINE_W-1:0] r_data  [N_ENTRY];
  logic [IDX_W-1:0]  r_tail, r_aw_ptr, r_w_ptr, r_head;
  logic              r_err;

  logic              w_enq, w_aw_hs, w_wlast_hs, w_retire;
  logic              w_b_known, w_b_ok, w_b_bad;
  logic [IDX_W-1:0]  w_b_idx;
  logic              w_lkp_hit, w_new_hit;

  assign w_enq    = new_valid_i & new_ready_o;
  assign w_aw_hs  = l2_req_if_awvalid & l2_req_if_awready;
  assign w_retire = (r_state[r_head] == DONE);
  assign w_b_idx  = l2_resp_if_b.bid.tid[IDX_W-1:0];

  // A B beat is only honoured for our bank, an existing slot, and a slot that is waiting for it.
  assign w_b_known = (l2_resp_if_b.bid.bid == MEM_BID_W'(BANK_ID)) &&
                     ({1'b0, l2_resp_if_b.bid.tid} < (MEM_TID_W + 1)'(N_ENTRY));
  assign w_b_ok    = l2_resp_if_bvalid & w_b_known & (r_state[w_b_idx] == B_WAIT);
  assign w_b_bad   = l2_resp_if_bvalid & (~w_b_ok | (l2_resp_if_b.bresp != AXI_RESP_OKAY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        r_state[i] <= FREE;
        r_addr[i]  <= '0;
      end
      r_tail   <= '0;
      r_aw_ptr <= '0;
      r_w_ptr  <= '0;
      r_head   <= '0;
      r_err    <= 1'b0;
    end else begin
      // Each event targets an entry in a distinct state, so at most one fires per entry.
      for (int i = 0; i < N_ENTRY; i++) begin
        if (w_enq && r_tail == IDX_W'(i)) begin
          r_state[i] <= AW_PEND;
          r_addr[i]  <= new_addr_i;
        end else if (w_aw_hs && r_aw_ptr == IDX_W'(i)) begin
          r_state[i] <= W_PEND;
        end else if (w_wlast_hs && r_w_ptr == IDX_W'(i)) begin
          r_state[i] <= B_WAIT;
        end else if (w_b_ok && w_b_idx == IDX_W'(i)) begin
          r_state[i] <= DONE;
        end else if (w_retire && r_head == IDX_W'(i)) begin
          r_state[i] <= FREE;
        end
      end
      if (w_enq)      r_tail   <= r_tail + IDX_W'(1);
      if (w_aw_hs)    r_aw_ptr <= r_aw_ptr + IDX_W'(1);
      if (w_wlast_hs) r_w_ptr  <= r_w_ptr + IDX_W'(1);
      if (w_retire)   r_head   <= r_head + IDX_W'(1);
      r_err <= r_err | w_b_bad;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ENTRY; i++) begin
      if (w_enq && r_tail == IDX_W'(i)) r_data[i] <= new_dat_i;
    end
  end

  assign new_ready_o       = (r_state[r_tail] == FREE);
  assign idle_o            = (entry_vld_o == '0);
  assign err_o             = r_err;
  assign l2_resp_if_bready = 1'b1;

  assign l2_req_if_awvalid = (r_state[r_aw_ptr] == AW_PEND);
  always_comb begin
    l2_req_if_aw          = '0;
    l2_req_if_aw.awid.bid = MEM_BID_W'(BANK_ID);
    l2_req_if_aw.awid.tid = MEM_TID_W'(r_aw_ptr);
    l2_req_if_aw.awaddr   = {r_addr[r_aw_ptr], {L1D_OFFSET_W{1'b0}}};
    l2_req_if_aw.awlen    = 8'(BURST_LEN - 1);
    l2_req_if_aw.awsize   = AXI_SIZE;
    l2_req_if_aw.awburst  = AXI_BURST_INCR;
  end

  assign l2_req_if_wvalid    = (r_state[r_w_ptr] == W_PEND);
  assign l2_req_if_w.wid.bid = MEM_BID_W'(BANK_ID);
  assign l2_req_if_w.wid.tid = MEM_TID_W'(r_w_ptr);

  rvh_l1d_wbq_wbeat #(
    .LINE_W    (LINE_W),
    .BEAT_W    (BEAT_W),
    .BURST_LEN (BURST_LEN)
  ) u_wbeat (
    .clk       (clk),
    .rst       (rst),
    .i_line    (r_data[r_w_ptr]),
    .i_valid   (l2_req_if_wvalid),
    .i_ready   (l2_req_if_wready),
    .o_data    (l2_req_if_w.wdata),
    .o_last    (l2_req_if_w.wlast),
    .o_last_hs (w_wlast_hs)
  );

  for (genvar g = 0; g < N_ENTRY; g++) begin : g_entry
    assign entry_addr_o[g*ADDR_W +: ADDR_W] = r_addr[g];
    assign entry_vld_o[g]                   = (r_state[g] != FREE);
  end

`ifdef RVH_L1D_WBQ_FWD_EN
  logic [LINE_W-1:0] w_lkp_dat;
`endif

  // Addresses are unique among live entries, so the OR-reduction acts as a one-hot mux.
  always_comb begin
    w_lkp_hit = 1'b0;
    w_new_hit = 1'b0;
`ifdef RVH_L1D_WBQ_FWD_EN
    w_lkp_dat = '0;
`endif
    for (int i = 0; i < N_ENTRY; i++) begin
      if (r_state[i] != FREE) begin
        if (r_addr[i] == lkp_addr_i) begin
          w_lkp_hit = 1'b1;
`ifdef RVH_L1D_WBQ_FWD_EN
          w_lkp_dat = w_lkp_dat | r_data[i];
`endif
        end
        if (r_addr[i] == new_addr_i) w_new_hit = 1'b1;
      end
    end
  end

  assign lkp_hit_o = w_lkp_hit;
`ifdef RVH_L1D_WBQ_FWD_EN
  assign lkp_dat_o = w_lkp_dat;
`else
  assign lkp_dat_o = '0;
`endif

  a_enq_unique: assert property (@(posedge clk) disable iff (!rst)
    !(new_valid_i && new_ready_o && w_new_hit));

  a_b_not_with_wlast: assert property (@(posedge clk) disable iff (!rst)
    !(w_wlast_hs && l2_resp_if_bvalid && l2_resp_if_b.bid.tid == MEM_TID_W'(r_w_ptr)));

endmodule
